// File: rtl/decode_stage.sv
// Registered RISC-V-style decode stage: splits the instruction word, assembles the
// I/S 12-bit immediate, and presents decoded entries through a 2-entry skid buffer.
module decode_stage #(
  parameter int          PC_W      = 32,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [PC_W-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [PC_W-1:0] out_pc,
  output logic [6:0]      out_opcode,
  output logic [4:0]      out_rd,
  output logic [2:0]      out_funct3,
  output logic [4:0]      out_rs1,
  output logic [4:0]      out_rs2,
  output logic [11:0]     out_imm12,
  output logic            out_imm_unsigned,
  output logic            out_illegal,
  output logic [15:0]     dec_count
);

  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  typedef struct packed {
    logic [PC_W-1:0] pc;
    logic [6:0]      opcode;
    logic [4:0]      rd;
    logic [2:0]      funct3;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [11:0]     imm12;
    logic            imm_unsigned;
    logic            illegal;
  } entry_t;

  function automatic entry_t decode(input logic [31:0] instr, input logic [PC_W-1:0] pc);
    entry_t d;
    d.pc           = pc;
    d.opcode       = instr[6:0];
    d.rd           = instr[11:7];
    d.funct3       = instr[14:12];
    d.rs1          = instr[19:15];
    d.rs2          = instr[24:20];
    d.imm12        = (instr[6:0] == OP_STORE) ? {instr[31:25], instr[11:7]} : instr[31:20];
    // Logical immediates (XORI/ORI/ANDI) are zero-extended downstream.
    d.imm_unsigned = (instr[6:0] == OP_IMM) &&
                     ((instr[14:12] == 3'b100) || (instr[14:12] == 3'b110) ||
                      (instr[14:12] == 3'b111));
    d.illegal      = !((instr[6:0] == OP_IMM)  || (instr[6:0] == OP_LOAD) ||
                       (instr[6:0] == OP_STORE) || (instr[6:0] == OP_REG) ||
                       (instr[6:0] == OP_JALR));
    return d;
  endfunction

  localparam entry_t NOP_ENTRY = decode(NOP_INSTR, {PC_W{1'b0}});

  entry_t      h_q, h_d;
  entry_t      s_q, s_d;
  logic        h_valid_q, h_valid_d;
  logic        s_valid_q, s_valid_d;
  logic [15:0] dec_count_q, dec_count_d;

  entry_t      in_entry;
  logic        in_fire;
  logic        out_fire;

  assign in_entry = decode(in_instr, in_pc);
  assign in_fire  = in_valid && in_ready;
  assign out_fire = h_valid_q && out_ready;

  always_comb begin
    h_d         = h_q;
    s_d         = s_q;
    h_valid_d   = h_valid_q;
    s_valid_d   = s_valid_q;
    dec_count_d = out_fire ? dec_count_q + 16'd1 : dec_count_q;

    if (flush) begin
      h_d       = NOP_ENTRY;
      s_d       = NOP_ENTRY;
      h_valid_d = 1'b0;
      s_valid_d = 1'b0;
    end else if (!h_valid_q || out_fire) begin
      // Head is free this cycle: refill from skid first to keep order.
      if (s_valid_q) begin
        h_d       = s_q;
        s_valid_d = 1'b0;
        h_valid_d = 1'b1;
      end else if (in_fire) begin
        h_d       = in_entry;
        h_valid_d = 1'b1;
      end else begin
        h_valid_d = 1'b0;
      end
    end else if (in_fire) begin
      s_d       = in_entry;
      s_valid_d = 1'b1;
    end
  end

  // Release of rst_n is expected to be synchronous to clk.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_q         <= NOP_ENTRY;
      s_q         <= NOP_ENTRY;
      h_valid_q   <= 1'b0;
      s_valid_q   <= 1'b0;
      dec_count_q <= 16'd0;
    end else begin
      h_q         <= h_d;
      s_q         <= s_d;
      h_valid_q   <= h_valid_d;
      s_valid_q   <= s_valid_d;
      dec_count_q <= dec_count_d;
    end
  end

  assign in_ready         = !s_valid_q;
  assign out_valid        = h_valid_q;
  assign out_pc           = h_q.pc;
  assign out_opcode       = h_q.opcode;
  assign out_rd           = h_q.rd;
  assign out_funct3       = h_q.funct3;
  assign out_rs1          = h_q.rs1;
  assign out_rs2          = h_q.rs2;
  assign out_imm12        = h_q.imm12;
  assign out_imm_unsigned = h_q.imm_unsigned;
  assign out_illegal      = h_q.illegal;
  assign dec_count        = dec_count_q;

endmodule

// File: tb/tb_decode_stage.sv
// Scoreboard bench for decode_stage: a driver pushes expected decodes, a monitor
// pops and compares on every output transfer.
module tb_decode_stage;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_instr = 32'h0;
  logic [31:0] in_pc = 32'h0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_pc;
  logic [6:0]  out_opcode;
  logic [4:0]  out_rd;
  logic [2:0]  out_funct3;
  logic [4:0]  out_rs1;
  logic [4:0]  out_rs2;
  logic [11:0] out_imm12;
  logic        out_imm_unsigned;
  logic        out_illegal;
  logic [15:0] dec_count;

  decode_stage #(.PC_W(32), .NOP_INSTR(32'h0000_0013)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
    .out_opcode(out_opcode), .out_rd(out_rd), .out_funct3(out_funct3),
    .out_rs1(out_rs1), .out_rs2(out_rs2), .out_imm12(out_imm12),
    .out_imm_unsigned(out_imm_unsigned), .out_illegal(out_illegal),
    .dec_count(dec_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] pc;
    logic [6:0]  op;
    logic [4:0]  rd;
    logic [2:0]  f3;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [11:0] imm;
    logic        uns;
    logic        ill;
  } exp_t;

  exp_t        exp_q[$];
  int          n_checks = 0;
  int          n_pass = 0;
  int          n_out = 0;
  logic [15:0] exp_count = 16'd0;
  bit          quiet = 1'b0;

  // Reference decode straight from the field-layout rules, using shifts and masks.
  function automatic exp_t model(input logic [31:0] w, input logic [31:0] pc);
    exp_t e;
    int   op;
    int   f3;
    op    = int'(w & 32'h7F);
    f3    = int'((w >> 12) & 32'h7);
    e.pc  = pc;
    e.op  = 7'(op);
    e.rd  = 5'((w >> 7) & 32'h1F);
    e.f3  = 3'(f3);
    e.rs1 = 5'((w >> 15) & 32'h1F);
    e.rs2 = 5'((w >> 20) & 32'h1F);
    if (op == 'h23) e.imm = 12'((((w >> 25) & 32'h7F) << 5) | ((w >> 7) & 32'h1F));
    else            e.imm = 12'(w >> 20);
    e.uns = (op == 'h13) && (f3 == 4 || f3 == 6 || f3 == 7);
    e.ill = !(op == 'h13 || op == 'h03 || op == 'h23 || op == 'h33 || op == 'h67);
    return e;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %0h required %0h", name, act, req);
  endtask

  function automatic exp_t got_entry();
    return {out_pc, out_opcode, out_rd, out_funct3, out_rs1, out_rs2,
            out_imm12, out_imm_unsigned, out_illegal};
  endfunction

  // Monitor: every output transfer is checked against the oldest expected entry.
  always @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exp_q.delete();
      exp_count = 16'd0;
      n_out = 0;
    end else begin
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_output", {32'h0, out_pc}, 64'hFFFF_FFFF_FFFF_FFFF);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          if (!quiet)
            $display("out pc=%08h op=%02h rd=%0d f3=%0d rs1=%0d rs2=%0d imm=%03h uns=%0b ill=%0b cnt=%0d",
                     out_pc, out_opcode, out_rd, out_funct3, out_rs1, out_rs2,
                     out_imm12, out_imm_unsigned, out_illegal, dec_count);
          chk("entry", 64'(got_entry()), 64'(e));
          chk("dec_count", 64'(dec_count), 64'(exp_count));
        end
        exp_count = exp_count + 16'd1;
        n_out++;
      end
      if (flush) exp_q.delete();
    end
  end

  function automatic logic [31:0] rand_instr();
    logic [6:0] ops [6];
    logic [31:0] w;
    ops[0] = 7'h13; ops[1] = 7'h03; ops[2] = 7'h23;
    ops[3] = 7'h33; ops[4] = 7'h67; ops[5] = 7'($urandom);
    w = $urandom;
    w[6:0] = ops[$urandom_range(0, 5)];
    return w;
  endfunction

  // One clock of stimulus, entered and left at posedge+1.
  task automatic drive_cycle(input logic iv, input logic [31:0] w, input logic [31:0] pc,
                             input logic ordy, input logic fl);
    in_valid = iv; in_instr = w; in_pc = pc; out_ready = ordy; flush = fl;
    @(negedge clk);
    if (rst_n && in_valid && in_ready && !flush) exp_q.push_back(model(in_instr, in_pc));
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] w, input logic [31:0] pc);
    int n;
    in_valid = 1'b1; in_instr = w; in_pc = pc;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      n++;
      @(negedge clk);
    end
    chk("send_accept_timeout", 64'(in_ready), 64'd1);
    if (in_ready && !flush) exp_q.push_back(model(w, pc));
    if (!quiet) $display("in  pc=%08h instr=%08h", pc, w);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  initial begin
    logic [31:0] pc;
    int guard;

    #12;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_dec_count", 64'(dec_count), 64'd0);
    chk("rst_out_pc", 64'(out_pc), 64'd0);
    chk("rst_fields", 64'(got_entry()), 64'(model(32'h13, 32'h0)));
    @(posedge clk); #1;
    rst_n = 1'b1;

    out_ready = 1'b1;
    send(32'hFFF0_0093, 32'h100);
    chk("itype_valid", 64'(out_valid), 64'd1);
    chk("itype_opcode", 64'(out_opcode), 64'h13);
    chk("itype_rd", 64'(out_rd), 64'd1);
    chk("itype_imm12", 64'(out_imm12), 64'hFFF);
    chk("itype_unsigned", 64'(out_imm_unsigned), 64'd0);
    @(posedge clk); #1;
    chk("itype_count", 64'(dec_count), 64'd1);
    chk("itype_drained", 64'(out_valid), 64'd0);

    send(32'h0021_A423, 32'h104);
    chk("stype_imm12", 64'(out_imm12), 64'h008);
    chk("stype_rs1_rs2", 64'({out_rs1, out_rs2}), 64'({5'd3, 5'd2}));
    send(32'h0F03_7293, 32'h108);
    chk("andi_imm12", 64'(out_imm12), 64'h0F0);
    chk("andi_unsigned", 64'(out_imm_unsigned), 64'd1);
    @(posedge clk); #1;
    chk("andi_count", 64'(dec_count), 64'd3);

    // Backpressure: A in head, B in skid.
    out_ready = 1'b0;
    send(32'h0010_0113, 32'h200);
    send(32'h0020_0193, 32'h204);
    chk("bp_in_ready_low", 64'(in_ready), 64'd0);
    chk("bp_head_is_a", 64'(out_pc), 64'h200);
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_head_is_b", 64'(out_pc), 64'h204);
    chk("bp_in_ready_high", 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    chk("bp_count", 64'(dec_count), 64'd5);

    // Flush with both entries full and C on the input.
    out_ready = 1'b0;
    send(32'h0030_0213, 32'h300);
    send(32'h0040_0293, 32'h304);
    drive_cycle(1'b1, 32'h0050_0313, 32'h308, 1'b0, 1'b1);
    flush = 1'b0; in_valid = 1'b0;
    chk("flush_out_valid", 64'(out_valid), 64'd0);
    chk("flush_in_ready", 64'(in_ready), 64'd1);
    chk("flush_nop_opcode", 64'(out_opcode), 64'h13);
    chk("flush_count", 64'(dec_count), 64'd5);
    repeat (3) drive_cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

    // Randomized traffic with occasional flush.
    pc = 32'h1000;
    for (int i = 0; i < 3000; i++) begin
      drive_cycle(($urandom_range(0, 3) != 0), rand_instr(), pc,
                  ($urandom_range(0, 3) != 0), ($urandom_range(0, 31) == 0));
      pc = pc + 4;
    end
    repeat (4) drive_cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    chk("random_drained", 64'(exp_q.size()), 64'd0);

    // Counter wrap after a fresh reset.
    rst_n = 1'b0; #2; rst_n = 1'b1;
    @(posedge clk); #1;
    quiet = 1'b1;
    guard = 0;
    while (n_out < 65536 && guard < 70000) begin
      drive_cycle(1'b1, rand_instr(), pc, 1'b1, 1'b0);
      pc = pc + 4;
      guard++;
    end
    quiet = 1'b0;
    chk("wrap_deliveries", 64'(n_out), 64'd65536);
    chk("wrap_count_zero", 64'(dec_count), 64'd0);

    // Asynchronous reset while the head is full.
    chk("pre_reset_valid", 64'(out_valid), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_out_valid", 64'(out_valid), 64'd0);
    chk("arst_in_ready", 64'(in_ready), 64'd1);
    chk("arst_fields", 64'(got_entry()), 64'(model(32'h13, 32'h0)));
    chk("arst_count", 64'(dec_count), 64'd0);
    in_valid = 1'b0; out_ready = 1'b0;
    #3 rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post_reset_ready", 64'(in_ready), 64'd1);
    send(32'h0000_8067, 32'h400);
    chk("post_reset_valid", 64'(out_valid), 64'd1);
    chk("post_reset_pc", 64'(out_pc), 64'h400);
    repeat (2) drive_cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    chk("post_reset_count", 64'(dec_count), 64'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
